imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: boots an instruction memory from a byte stream while holding the CPU in reset.
//
// Stream format: LEN[7:0], LEN[15:8], then 4*LEN data bytes; each word little-endian.
// A LEN of zero finishes immediately. A LEN larger than the memory depth is rejected.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - asynchronous, active-low reset
//   start      - begin a (re)load; only honoured in IDLE, DONE and ERR
//   in_valid   - byte-stream source has a byte
//   in_data    - byte-stream payload
//   in_ready   - loader accepts a byte this cycle (independent of in_valid)
//   mem_we     - instruction-memory write strobe (one cycle per word)
//   mem_addr   - word address of the write
//   mem_wdata  - assembled instruction word
//   cpu_hold   - high while the processor must stay in reset
//   done       - load completed
//   error      - load rejected because LEN exceeds the memory depth
module imem_loader #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        StIdle,
        StLenLo,
        StLenHi,
        StData,
        StWrite,
        StDone,
        StErr
    } state_t;

    // 17 bits so a depth of 2**16 words is still representable.
    localparam logic [16:0] MAX_LEN = 17'd1 << ADDR_W;

    state_t              r_state;
    state_t              w_next_state;
    logic [7:0]          r_len_lo;
    logic [15:0]         r_remaining;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_word;
    logic [1:0]          r_byte_idx;
    logic                w_xfer;
    logic [16:0]         w_len;

    assign w_xfer = in_valid & in_ready;
    // Only meaningful while the high length byte is on in_data.
    assign w_len  = {1'b0, in_data, r_len_lo};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        mem_we       = 1'b0;
        cpu_hold     = 1'b1;
        done         = 1'b0;
        error        = 1'b0;
        case (r_state)
            StIdle: begin
                if (start) w_next_state = StLenLo;
            end
            StLenLo: begin
                in_ready = 1'b1;
                if (in_valid) w_next_state = StLenHi;
            end
            StLenHi: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (w_len == 17'd0) begin
                        w_next_state = StDone;
                    end else if (w_len > MAX_LEN) begin
                        w_next_state = StErr;
                    end else begin
                        w_next_state = StData;
                    end
                end
            end
            StData: begin
                in_ready = 1'b1;
                if (in_valid && (r_byte_idx == 2'd3)) w_next_state = StWrite;
            end
            StWrite: begin
                mem_we       = 1'b1;
                w_next_state = (r_remaining == 16'd1) ? StDone : StData;
            end
            StDone: begin
                cpu_hold = 1'b0;
                done     = 1'b1;
                if (start) w_next_state = StLenLo;
            end
            StErr: begin
                error = 1'b1;
                if (start) w_next_state = StLenLo;
            end
            default: begin
                w_next_state = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_len_lo    <= '0;
            r_remaining <= '0;
            r_addr      <= '0;
            r_word      <= '0;
            r_byte_idx  <= '0;
        end else begin
            case (r_state)
                StLenLo: begin
                    if (w_xfer) r_len_lo <= in_data;
                end
                StLenHi: begin
                    if (w_xfer) begin
                        r_remaining <= w_len[15:0];
                        r_addr      <= '0;
                        r_byte_idx  <= '0;
                    end
                end
                StData: begin
                    if (w_xfer) begin
                        r_word[{r_byte_idx, 3'b000} +: 8] <= in_data;
                        r_byte_idx                        <= r_byte_idx + 2'd1;
                    end
                end
                StWrite: begin
                    r_remaining <= r_remaining - 16'd1;
                    // Hold the address on the last word so a full-depth load never wraps.
                    if (r_remaining != 16'd1) r_addr <= r_addr + ADDR_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_word;

endmodule
